// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the MEM-stage data memory access controller.
//   - funct3 load/store width codes
//   - controller FSM state encoding
//   - helpers decoding access size and legality from funct3
package mem_access_ctrl_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE,
        REQ1,
        WAIT1,
        REQ2,
        WAIT2,
        DONE
    } state_t;

    // Access size in bytes (1, 2 or 4) from the width bits of funct3.
    function automatic logic [2:0] access_size(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   access_size = 3'd1;
            2'b01:   access_size = 3'd2;
            default: access_size = 3'd4;
        endcase
    endfunction

    function automatic logic type_legal(input logic [2:0] f3);
        type_legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                     (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/Data_organizer.sv
// Load result extension: sign- or zero-extends the right-justified raw
// read data according to funct3.
//   data_in  : right-justified raw load data
//   funct3   : load type (B, H, W, BU, HU)
//   data_out : extended 32-bit load result
module Data_organizer
    import mem_access_ctrl_pkg::*;
(
    input  logic [31:0] data_in,
    input  logic [2:0]  funct3,
    output logic [31:0] data_out
);

    always_comb begin
        data_out = data_in;
        case (funct3)
            F3_B:    data_out = {{24{data_in[7]}},  data_in[7:0]};
            F3_H:    data_out = {{16{data_in[15]}}, data_in[15:0]};
            F3_BU:   data_out = {24'd0, data_in[7:0]};
            F3_HU:   data_out = {16'd0, data_in[15:0]};
            default: data_out = data_in;
        endcase
    end

endmodule

// File: rtl/mem_lane_align.sv
// Combinational byte-lane alignment for word-organised memory.
//   off      : byte offset within the word (addr[1:0])
//   size     : access size in bytes (1, 2, 4)
//   wdata    : right-justified store data
//   rd_hi/lo : second / first returned read word (hi=0 when single beat)
//   be1/be2  : byte enables for beat 1 / beat 2
//   wdata1/2 : lane-shifted write data for beat 1 / beat 2
//   two_beat : access crosses a word boundary
//   raw      : merged, right-justified read data
module mem_lane_align (
    input  logic [1:0]  off,
    input  logic [2:0]  size,
    input  logic [31:0] wdata,
    input  logic [31:0] rd_hi,
    input  logic [31:0] rd_lo,
    output logic [3:0]  be1,
    output logic [3:0]  be2,
    output logic [31:0] wdata1,
    output logic [31:0] wdata2,
    output logic        two_beat,
    output logic [31:0] raw
);

    logic [7:0]  be8;
    logic [5:0]  sh;
    logic [63:0] wide_w;

    assign sh  = {1'b0, off, 3'b000};
    assign be8 = ((8'd1 << size) - 8'd1) << off;

    // Shifting in a 64-bit window yields both beats at once: the upper
    // half equals wdata >> 8*(4-off) without a 32-bit shift corner case.
    assign wide_w = {32'd0, wdata} << sh;

    assign be1      = be8[3:0];
    assign be2      = be8[7:4];
    assign two_beat = |be8[7:4];
    assign wdata1   = wide_w[31:0];
    assign wdata2   = wide_w[63:32];
    assign raw      = 32'({rd_hi, rd_lo} >> sh);

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store sequencer for a single-port word-organised data
// memory using a req/gnt/rvalid handshake. Unaligned accesses crossing a
// word boundary are split into two aligned beats.
//   clk, rst_n             : clock, synchronous active-low reset
//   req_valid/we/addr/     : load/store request from EX/MEM register
//   wdata/type
//   stall                  : pipeline hold (req_valid & ~done)
//   done, err, load_data   : one-cycle completion, illegal type, load result
//   mem_req/we/addr/be/    : memory request side
//   wdata, mem_gnt
//   mem_rvalid, mem_rdata  : memory read response
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    input  logic            req_we,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [2:0]      req_type,
    output logic            stall,
    output logic            done,
    output logic            err,
    output logic [XLEN-1:0] load_data,
    output logic            mem_req,
    input  logic            mem_gnt,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [3:0]      mem_be,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata
);

    state_t          state_q, state_d;
    logic            we_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [2:0]      type_q;
    logic [XLEN-1:0] lo_q;
    logic            err_q;

    logic [3:0]      be1, be2;
    logic [XLEN-1:0] wdata1, wdata2;
    logic            two_beat;
    logic [XLEN-1:0] merge_hi, merge_lo;
    logic [XLEN-1:0] raw, org_data;
    logic [XLEN-1:0] base_addr;
    logic            load_fin;

    // The final read word is merged straight from mem_rdata so the result
    // can be registered on the same edge that enters DONE.
    always_comb begin
        if (state_q == WAIT1) begin
            merge_hi = '0;
            merge_lo = mem_rdata;
        end else begin
            merge_hi = mem_rdata;
            merge_lo = lo_q;
        end
    end

    mem_lane_align u_align (
        .off      (addr_q[1:0]),
        .size     (access_size(type_q)),
        .wdata    (wdata_q),
        .rd_hi    (merge_hi),
        .rd_lo    (merge_lo),
        .be1      (be1),
        .be2      (be2),
        .wdata1   (wdata1),
        .wdata2   (wdata2),
        .two_beat (two_beat),
        .raw      (raw)
    );

    Data_organizer u_org (
        .data_in  (raw),
        .funct3   (type_q),
        .data_out (org_data)
    );

    assign base_addr = {addr_q[XLEN-1:2], 2'b00};
    assign load_fin  = mem_rvalid &&
                       (((state_q == WAIT1) && !two_beat) || (state_q == WAIT2));
    assign stall     = req_valid & ~done;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            type_q    <= '0;
            lo_q      <= '0;
            err_q     <= 1'b0;
            load_data <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == IDLE) && req_valid) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                type_q  <= req_type;
                err_q   <= ~type_legal(req_type);
            end
            if ((state_q == WAIT1) && mem_rvalid) begin
                lo_q <= mem_rdata;
            end
            if (load_fin) begin
                load_data <= org_data;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_be    = '0;
        mem_wdata = '0;
        done      = 1'b0;
        err       = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = type_legal(req_type) ? REQ1 : DONE;
                end
            end
            REQ1: begin
                mem_req   = 1'b1;
                mem_we    = we_q;
                mem_addr  = base_addr;
                mem_be    = be1;
                mem_wdata = wdata1;
                if (mem_gnt) begin
                    if (!we_q)         state_d = WAIT1;
                    else if (two_beat) state_d = REQ2;
                    else               state_d = DONE;
                end
            end
            WAIT1: begin
                if (mem_rvalid) begin
                    state_d = two_beat ? REQ2 : DONE;
                end
            end
            REQ2: begin
                mem_req   = 1'b1;
                mem_we    = we_q;
                mem_addr  = base_addr + 32'd4;
                mem_be    = be2;
                mem_wdata = wdata2;
                if (mem_gnt) begin
                    state_d = we_q ? DONE : WAIT2;
                end
            end
            WAIT2: begin
                if (mem_rvalid) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                err     = err_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_type;
    logic        stall;
    logic        done;
    logic        err;
    logic [31:0] load_data;
    logic        mem_req;
    logic        mem_gnt;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int tests_run;
    int tests_failed;

    logic [31:0] mem [256];

    mem_access_ctrl #(.XLEN(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_type   (req_type),
        .stall      (stall),
        .done       (done),
        .err        (err),
        .load_data  (load_data),
        .mem_req    (mem_req),
        .mem_gnt    (mem_gnt),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  typ;
        logic [3:0]  be1;
        logic [31:0] a1;
        logic [31:0] wd1;
        logic        two;
        logic [3:0]  be2;
        logic [31:0] a2;
        logic [31:0] wd2;
        logic [31:0] ld;
        logic        er;
        int          lat;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Drives one request, acts as the memory (grant after gd waiting
    // cycles, rvalid rd cycles after the first wait cycle) and checks it.
    task automatic run_txn(input vec_t v, input int gd, input int rd,
                           input int exp_lat, input bit scramble);
        int          cyc = 0;
        int          grants = 0;
        int          waited = 0;
        int          cnt = 0;
        bit          pend = 0;
        bit          seen = 0;
        logic [31:0] pdata = '0;
        int          exp_grants;
        exp_grants = v.er ? 0 : (v.two ? 2 : 1);
        req_valid = 1'b1;
        req_we    = v.we;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        req_type  = v.typ;
        #1;
        check("stall_on_req", {31'd0, stall}, 32'd1);
        while (!seen && cyc < 60) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            mem_rdata  = '0;
            if (scramble) begin
                req_we    = ~v.we;
                req_addr  = ~v.addr;
                req_wdata = ~v.wdata;
                req_type  = 3'b010;
            end
            #1;
            if (done) begin
                seen = 1;
                check("latency", cyc, exp_lat);
                check("load_data", load_data, v.ld);
                check("err", {31'd0, err}, {31'd0, v.er});
                check("stall_at_done", {31'd0, stall}, 32'd0);
                check("grants", grants, exp_grants);
            end else begin
                check("stall_busy", {31'd0, stall}, 32'd1);
                if (pend) begin
                    if (cnt == 0) begin
                        mem_rvalid = 1'b1;
                        mem_rdata  = pdata;
                        pend = 0;
                    end else begin
                        cnt--;
                    end
                end
                if (mem_req) begin
                    if (grants == 0) begin
                        check("be1", {28'd0, mem_be}, {28'd0, v.be1});
                        check("addr1", mem_addr, v.a1);
                        check("wdata1", mem_wdata, v.wd1);
                    end else begin
                        check("be2", {28'd0, mem_be}, {28'd0, v.be2});
                        check("addr2", mem_addr, v.a2);
                        check("wdata2", mem_wdata, v.wd2);
                    end
                    check("mem_we", {31'd0, mem_we}, {31'd0, v.we});
                    if (waited >= gd) begin
                        mem_gnt = 1'b1;
                        grants++;
                        waited = 0;
                        if (!v.we) begin
                            pend  = 1;
                            cnt   = rd;
                            pdata = mem[mem_addr[9:2]];
                        end
                    end else begin
                        waited++;
                    end
                end
            end
        end
        if (!seen) begin
            tests_run++;
            tests_failed++;
            $display("FAIL timeout: no done after %0d cycles", cyc);
        end
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_type  = '0;
        @(posedge clk);
        @(negedge clk);
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        #1;
        check("done_once", {31'd0, done}, 32'd0);
        check("idle_no_req", {31'd0, mem_req}, 32'd0);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        req_type   = '0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;

        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[8'h40] = 32'h8765_4321;  // 0x100
        mem[8'h50] = 32'h8012_3456;  // 0x140
        mem[8'h60] = 32'hBBBB_AAAA;  // 0x180
        mem[8'h61] = 32'hDDDD_CCCC;  // 0x184
        mem[8'h70] = 32'h9ABC_1234;  // 0x1C0
        mem[8'h80] = 32'h0000_F00D;  // 0x200
        mem[8'hFF] = 32'h5566_7788;  // 0xFFFF_FFFC
        mem[8'h00] = 32'h1122_3344;  // 0x0000_0000

        //            we    addr           wdata          typ     be1   a1             wd1            two   be2   a2             wd2            ld             er    lat
        vecs[0]  = '{1'b0, 32'h0000_0100, 32'h0,         3'b010, 4'hF, 32'h0000_0100, 32'h0,         1'b0, 4'h0, 32'h0,         32'h0,         32'h8765_4321, 1'b0, 3};
        vecs[1]  = '{1'b0, 32'h0000_0143, 32'h0,         3'b000, 4'h8, 32'h0000_0140, 32'h0,         1'b0, 4'h0, 32'h0,         32'h0,         32'hFFFF_FF80, 1'b0, 3};
        vecs[2]  = '{1'b0, 32'h0000_0143, 32'h0,         3'b100, 4'h8, 32'h0000_0140, 32'h0,         1'b0, 4'h0, 32'h0,         32'h0,         32'h0000_0080, 1'b0, 3};
        vecs[3]  = '{1'b0, 32'h0000_0182, 32'h0,         3'b010, 4'hC, 32'h0000_0180, 32'h0,         1'b1, 4'h3, 32'h0000_0184, 32'h0,         32'hCCCC_BBBB, 1'b0, 5};
        vecs[4]  = '{1'b1, 32'h0000_0103, 32'h0000_1234, 3'b001, 4'h8, 32'h0000_0100, 32'h3400_0000, 1'b1, 4'h1, 32'h0000_0104, 32'h0000_0012, 32'hCCCC_BBBB, 1'b0, 3};
        vecs[5]  = '{1'b1, 32'h0000_0200, 32'hCAFE_BABE, 3'b010, 4'hF, 32'h0000_0200, 32'hCAFE_BABE, 1'b0, 4'h0, 32'h0,         32'h0,         32'hCCCC_BBBB, 1'b0, 2};
        vecs[6]  = '{1'b0, 32'h0000_01C2, 32'h0,         3'b001, 4'hC, 32'h0000_01C0, 32'h0,         1'b0, 4'h0, 32'h0,         32'h0,         32'hFFFF_9ABC, 1'b0, 3};
        vecs[7]  = '{1'b0, 32'h0000_01C2, 32'h0,         3'b101, 4'hC, 32'h0000_01C0, 32'h0,         1'b0, 4'h0, 32'h0,         32'h0,         32'h0000_9ABC, 1'b0, 3};
        vecs[8]  = '{1'b0, 32'hFFFF_FFFE, 32'h0,         3'b010, 4'hC, 32'hFFFF_FFFC, 32'h0,         1'b1, 4'h3, 32'h0000_0000, 32'h0,         32'h3344_5566, 1'b0, 5};
        vecs[9]  = '{1'b1, 32'h0000_0001, 32'h0000_00A5, 3'b000, 4'h2, 32'h0000_0000, 32'h0000_A500, 1'b0, 4'h0, 32'h0,         32'h0,         32'h3344_5566, 1'b0, 2};
        vecs[10] = '{1'b0, 32'h0000_0100, 32'h0,         3'b011, 4'h0, 32'h0,         32'h0,         1'b0, 4'h0, 32'h0,         32'h0,         32'h3344_5566, 1'b1, 1};
        vecs[11] = '{1'b1, 32'h0000_00FE, 32'hAABB_CCDD, 3'b010, 4'hC, 32'h0000_00FC, 32'hCCDD_0000, 1'b1, 4'h3, 32'h0000_0100, 32'h0000_AABB, 32'h3344_5566, 1'b0, 3};
        vecs[12] = '{1'b0, 32'h0000_0100, 32'h0,         3'b110, 4'h0, 32'h0,         32'h0,         1'b0, 4'h0, 32'h0,         32'h0,         32'h3344_5566, 1'b1, 1};
        vecs[13] = '{1'b1, 32'h0000_0100, 32'h0,         3'b111, 4'h0, 32'h0,         32'h0,         1'b0, 4'h0, 32'h0,         32'h0,         32'h3344_5566, 1'b1, 1};

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_be", {28'd0, mem_be}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_load_data", load_data, 32'd0);

        for (int i = 0; i < 14; i++) begin
            run_txn(vecs[i], 0, 0, vecs[i].lat, 1'b0);
        end

        // LH 0x200 with slow grant and slow rvalid; request inputs are
        // scrambled after capture and must be ignored.
        begin
            vec_t v;
            v = '{1'b0, 32'h0000_0200, 32'h0, 3'b001, 4'h3, 32'h0000_0200, 32'h0,
                  1'b0, 4'h0, 32'h0, 32'h0, 32'hFFFF_F00D, 1'b0, 8};
            run_txn(v, 3, 2, 8, 1'b1);
        end

        // Reset while waiting for read data; a late rvalid must be ignored.
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h0000_0100;
        req_type  = 3'b010;
        @(posedge clk);
        @(negedge clk);
        #1;
        check("rstmid_req1", {31'd0, mem_req}, 32'd1);
        mem_gnt = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mem_gnt = 1'b0;
        #1;
        check("rstmid_wait_no_req", {31'd0, mem_req}, 32'd0);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = 1'b0;
        #1;
        check("rstmid_mem_req", {31'd0, mem_req}, 32'd0);
        check("rstmid_load_data", load_data, 32'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h8765_4321;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            mem_rvalid = 1'b0;
            #1;
            check("rstmid_no_done", {31'd0, done}, 32'd0);
            check("rstmid_no_err", {31'd0, err}, 32'd0);
            check("rstmid_ld_zero", load_data, 32'd0);
            check("rstmid_no_req", {31'd0, mem_req}, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
